keycode_queue_ctl: RTL and testbench
====================================

// Module: keycode_queue_ctl
// PURPOSE
//  Sits between the AT-to-lispm scancode converter and the CPU/Unibus keyboard register.
//  Captures each one-cycle keycode strobe into a small FIFO and sequences bus reads with a req/ack handshake.
//  Raises an interrupt while data is pending and flags lost keystrokes.
//  Keeps the converter free-running while the CPU reads at its own pace.
// PARAMETERS
//  AW      3   FIFO address width; depth = 2**AW entries (default 8)
//  KW      16  keycode width; matches the converter output
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      synchronous reset, active low
//  kc_strobe  in   1      one-cycle pulse: kc_code valid (converter strobe_out)
//  kc_code    in   KW     lispm keycode; bit 8 = key-up
//  rd_req     in   1      bus read request, level; held until rd_ack is seen
//  rd_ack     out  1      one-cycle read acknowledge
//  rd_data    out  KW     popped keycode; stable from rd_ack until the next read
//  rd_valid   out  1      1 = rd_data is a real entry; 0 = queue was empty
//  clr        in   1      one-cycle flush of queue and overflow flag
//  int_en     in   1      interrupt enable
//  irq        out  1      int_en & queue not empty (registered)
//  count      out  AW+1   current occupancy, 0..2**AW
//  overflow   out  1      sticky: a keycode was dropped because the queue was full
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge):
//   - wr_ptr, rd_ptr and count cleared; overflow=0; irq=0
//   - rd_ack=0, rd_valid=0, rd_data=0; read FSM enters R_IDLE
//   - reset mid-handshake abandons the read with no ack
//  Write side:
//   - kc_strobe & !full: store kc_code at wr_ptr, wr_ptr++ (wraps mod 2**AW)
//   - kc_strobe & full: drop code, overflow<=1, pointers unchanged
//  Read FSM:
//   - R_IDLE  -> R_FETCH when rd_req=1
//   - R_FETCH: if !empty: rd_data<=mem[rd_ptr], rd_valid<=1, rd_ptr++
//              else: rd_data unchanged, rd_valid<=0
//              always -> R_ACK
//   - R_ACK:  rd_ack=1 for exactly this cycle -> R_WAIT
//   - R_WAIT: -> R_IDLE when rd_req=0; a held rd_req never causes a second pop
//   - latency: rd_req seen in cycle N -> rd_ack high in cycle N+2
//  Occupancy:
//   - count += push - pop
//   - push and pop in the same cycle: both happen, count unchanged (legal at full and at empty)
//   - empty/full taken from the registered count: a push in the same cycle as R_FETCH on an
//     empty queue is not visible; the read returns rd_valid=0 and the entry stays queued
//  clr:
//   - pointers and count -> 0, overflow -> 0
//   - overrides a same-cycle push (code lost, overflow not set) and a same-cycle pop
//     (R_FETCH still completes with rd_valid=0)
//   - read FSM state is not affected
//  irq: registered; updates the cycle after count changes or int_en changes
//  Widths: pointers AW bits with natural wrap; count AW+1 bits so full = 2**AW
// CONFIGURATION
//  KQ_REPEAT_FILTER_EN
//   - defined: hold last_down (KW-1 bits, code without bit 8) plus a valid flag
//   - a key-down strobe equal to last_down while the flag is set is discarded (AT typematic
//     repeat); discarded codes do not set overflow
//   - any enqueued key-up clears the flag; any other enqueued key-down reloads last_down
//   - reset and clr clear the flag
//   - undefined: every strobe is enqueued subject only to full; no extra registers
// TESTING
//  1 Reset, then push 0x0021, 0x0121, then read twice -> rd_data 0x0021 then 0x0121;
//    rd_valid=1; rd_ack 2 cycles after each rd_req; count 2->1->0
//  2 Read with queue empty -> rd_ack once, rd_valid=0, count stays 0, irq=0
//  3 int_en=1, push 2**AW+1 codes -> count=8 (AW=3), overflow=1, irq=1;
//    drain 8 reads in push order; 9th code absent
//  4 Queue full; kc_strobe in the same cycle as R_FETCH -> pop and push both occur,
//    count stays 8, overflow stays 0, new code is read last
//  5 Push 3 codes, assert clr together with a kc_strobe -> count=0, overflow=0, irq=0,
//    next read returns rd_valid=0
//  6 With KQ_REPEAT_FILTER_EN: push 0x0015 x3, 0x0115, 0x0015 -> queue holds
//    0x0015, 0x0115, 0x0015; without the macro all 5 codes are queued

Source files
------------

// File: rtl/keycode_queue_ctl.sv
// keycode_queue_ctl: buffers converter keycode strobes in a small FIFO and
// hands them to the CPU through a req/ack read handshake. Raises irq while
// data is pending and keeps a sticky flag for keystrokes lost to a full queue.
// Optional build macro KQ_REPEAT_FILTER_EN drops AT typematic key-down repeats.
module keycode_queue_ctl #(
  parameter int AW = 3,
  parameter int KW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          kc_strobe,
  input  logic [KW-1:0] kc_code,
  input  logic          rd_req,
  output logic          rd_ack,
  output logic [KW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          clr,
  input  logic          int_en,
  output logic          irq,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_ACK, R_WAIT} rstate_t;

  rstate_t       state, state_nxt;
  logic [KW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, accept, push, pop;

  // Occupancy flags come from the registered count, so a push landing in the
  // same cycle as a fetch on an empty queue is not seen by that fetch.
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

`ifdef KQ_REPEAT_FILTER_EN
  logic [KW-2:0] last_down;
  logic          last_vld;
  logic [KW-2:0] code_key;
  logic          is_up;

  assign is_up    = kc_code[8];
  assign code_key = {kc_code[KW-1:9], kc_code[7:0]};
  // A key-down matching the last enqueued key-down is a typematic repeat.
  assign accept   = kc_strobe & ~(~is_up & last_vld & (code_key == last_down));

  // Track the most recent enqueued key-down; any enqueued key-up ends the run.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      last_vld <= 1'b0;
    end else if (push) begin
      if (is_up) begin
        last_vld <= 1'b0;
      end else begin
        last_vld  <= 1'b1;
        last_down <= code_key;
      end
    end
  end
`else
  assign accept = kc_strobe;
`endif

  // clr wins over both sides; at full a simultaneous pop frees the slot.
  assign pop  = (state == R_FETCH) & ~empty & ~clr;
  assign push = accept & (~full | pop) & ~clr;

  // Read sequencer state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= R_IDLE;
    else          state <= state_nxt;
  end

  // Read sequencer transitions; ack is a decode of the registered state.
  always_comb begin
    state_nxt = state;
    rd_ack    = 1'b0;
    case (state)
      R_IDLE:  if (rd_req) state_nxt = R_FETCH;
      R_FETCH: state_nxt = R_ACK;
      R_ACK: begin
        rd_ack    = 1'b1;
        state_nxt = R_WAIT;
      end
      R_WAIT:  if (!rd_req) state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  // Keycode storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= kc_code;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Sticky lost-keystroke flag; filtered repeats never reach here.
  always_ff @(posedge clk) begin
    if (!reset_n || clr)               overflow <= 1'b0;
    else if (accept && full && !pop)   overflow <= 1'b1;
  end

  // Read result: data holds its last value when the fetch found nothing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (state == R_FETCH) begin
      rd_valid <= pop;
      if (pop) rd_data <= mem[rd_ptr];
    end
  end

  // Interrupt follows the registered occupancy one cycle later.
  always_ff @(posedge clk) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= int_en & ~empty;
  end

endmodule

// File: tb/tb_keycode_queue_ctl.sv
// Scoreboard bench for keycode_queue_ctl: a queue-based reference model
// predicts every read result and per-cycle status; a monitor compares.
module tb_keycode_queue_ctl;

  localparam int AW = 3;
  localparam int KW = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          kc_strobe = 1'b0;
  logic [KW-1:0] kc_code = '0;
  logic          rd_req = 1'b0;
  logic          clr = 1'b0;
  logic          int_en = 1'b0;
  logic          rd_ack, rd_valid, irq, overflow;
  logic [KW-1:0] rd_data;
  logic [AW:0]   count;

  keycode_queue_ctl #(.AW(AW), .KW(KW)) dut (
    .clk(clk), .reset_n(reset_n), .kc_strobe(kc_strobe), .kc_code(kc_code),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr(clr), .int_en(int_en), .irq(irq), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic          v;
    logic [KW-1:0] d;
  } rd_t;

  logic [KW-1:0] m_q[$];
  rd_t           sb[$];
  bit            m_ovf, m_irq, m_ack, m_busy, m_fv;
  logic [KW-1:0] m_last;
  logic [KW-2:0] m_ld;
  int            m_e0, cyc;

  always @(posedge clk) begin
    int  pre;
    bit  fetch, popped, drop;
    rd_t r;
    cyc++;
    pre   = m_q.size();
    fetch = m_busy && (cyc == m_e0 + 1);
    if (!reset_n) begin
      m_q.delete();
      sb.delete();
      m_ovf = 0; m_irq = 0; m_ack = 0; m_busy = 0; m_fv = 0;
      m_last = '0;
    end else begin
      m_irq  = int_en && (pre != 0);
      m_ack  = fetch;
      popped = fetch && (pre != 0) && !clr;
      if (fetch) begin
        if (popped) begin
          r.v = 1'b1; r.d = m_q[0]; m_last = m_q[0];
        end else begin
          r.v = 1'b0; r.d = m_last;
        end
        sb.push_back(r);
      end
      if (clr) begin
        m_q.delete();
        m_ovf = 0;
        m_fv  = 0;
      end else begin
        if (popped) void'(m_q.pop_front());
        if (kc_strobe) begin
          drop = 0;
`ifdef KQ_REPEAT_FILTER_EN
          if (!kc_code[8] && m_fv && ({kc_code[15:9], kc_code[7:0]} == m_ld)) drop = 1;
`endif
          if (!drop) begin
            if ((pre - (popped ? 1 : 0)) >= DEPTH) begin
              m_ovf = 1;
            end else begin
              m_q.push_back(kc_code);
`ifdef KQ_REPEAT_FILTER_EN
              if (kc_code[8]) m_fv = 0;
              else begin m_fv = 1; m_ld = {kc_code[15:9], kc_code[7:0]}; end
`endif
            end
          end
        end
      end
      // a read is accepted when idle; a new one only after rd_req drops post-ack
      if (m_busy) begin
        if (cyc >= m_e0 + 3 && !rd_req) m_busy = 0;
      end else if (rd_req) begin
        m_busy = 1;
        m_e0   = cyc;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    rd_t r;
    if (reset_n) begin
      chk("count", 32'(count), 32'(m_q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("rd_ack", 32'(rd_ack), 32'(m_ack));
      if (rd_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(rd_ack), 32'd0);
        end else begin
          r = sb.pop_front();
          chk("rd_valid", 32'(rd_valid), 32'(r.v));
          chk("rd_data", 32'(rd_data), 32'(r.d));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic [KW-1:0] code);
    kc_strobe = 1'b1;
    kc_code   = code;
    @(negedge clk);
    kc_strobe = 1'b0;
  endtask

  task automatic rd();
    rd_req = 1'b1;
    repeat (4) @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rd_ack", 32'(rd_ack), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // T1: two pushes, two reads in order
    push(16'h0021);
    push(16'h0121);
    chk("t1_count2", 32'(count), 32'd2);
    rd();
    chk("t1_data0", 32'(rd_data), 32'h0021);
    chk("t1_count1", 32'(count), 32'd1);
    rd();
    chk("t1_data1", 32'(rd_data), 32'h0121);
    chk("t1_count0", 32'(count), 32'd0);

    // T2: read on empty queue
    rd();
    chk("t2_valid", 32'(rd_valid), 32'd0);
    chk("t2_irq", 32'(irq), 32'd0);

    // T3: overfill with interrupts enabled, then drain
    int_en = 1'b1;
    for (int i = 0; i <= DEPTH; i++) push(16'h0030 + 16'(i));
    @(negedge clk);
    chk("t3_count", 32'(count), 32'd8);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_irq", 32'(irq), 32'd1);
    for (int i = 0; i < DEPTH; i++) rd();
    chk("t3_last", 32'(rd_data), 32'h0037);

    // T4: full queue, push coincident with the fetch
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(16'h0040 + 16'(i));
    rd_req = 1'b1;
    @(negedge clk);
    kc_strobe = 1'b1; kc_code = 16'h0055;
    @(negedge clk);
    kc_strobe = 1'b0;
    chk("t4_count", 32'(count), 32'd8);
    chk("t4_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) rd();
    chk("t4_last", 32'(rd_data), 32'h0055);

    // T5: clr together with a strobe
    for (int i = 0; i < 3; i++) push(16'h0060 + 16'(i));
    clr = 1'b1; kc_strobe = 1'b1; kc_code = 16'h0077;
    @(negedge clk);
    clr = 1'b0; kc_strobe = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    chk("t5_irq", 32'(irq), 32'd0);
    rd();
    chk("t5_valid", 32'(rd_valid), 32'd0);

    // T6: typematic repeat sequence
    push(16'h0015); push(16'h0015); push(16'h0015); push(16'h0115); push(16'h0015);
`ifdef KQ_REPEAT_FILTER_EN
    chk("t6_count", 32'(count), 32'd3);
`else
    chk("t6_count", 32'(count), 32'd5);
`endif
    for (int i = 0; i < 5; i++) rd();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      kc_strobe = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 3) == 0) kc_code = 16'($urandom);
      else kc_code = (16'h0014 + 16'($urandom_range(0, 2))) |
                     (($urandom_range(0, 1) == 1) ? 16'h0100 : 16'h0000);
      clr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) int_en = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) rd_req = ~rd_req;
      @(negedge clk);
    end
    kc_strobe = 1'b0; clr = 1'b0; rd_req = 1'b0;
    repeat (10) @(negedge clk);

    // reset in the middle of a handshake abandons the read
    push(16'h0099);
    rd_req = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    rd_req = 1'b0;
    chk("midrst_ack", 32'(rd_ack), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
